// File: rtl/fetch_buffer.sv
// Instruction fetch unit with branch-predictor redirect and a circular instruction queue.
// A request is issued only when the queue can absorb it alongside any response already in flight.
module fetch_buffer #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  localparam int SLOT_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int DEQ_W  = $clog2(FETCH_WIDTH + 1),
  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic                               imem_req,
  output logic [PC_WIDTH-1:0]                imem_addr,
  input  logic [FETCH_WIDTH*INSTR_WIDTH-1:0] imem_rdata,
  input  logic                               bp_hit,
  input  logic                               bp_taken,
  input  logic [SLOT_W-1:0]                  bp_slot,
  input  logic [PC_WIDTH-1:0]                bp_target,
  input  logic                               redirect_valid,
  input  logic [PC_WIDTH-1:0]                redirect_pc,
  input  logic                               hlt,
  input  logic [DEQ_W-1:0]                   deq_count,
  output logic [FETCH_WIDTH-1:0]             out_valid,
  output logic [FETCH_WIDTH*INSTR_WIDTH-1:0] out_instr,
  output logic [FETCH_WIDTH*PC_WIDTH-1:0]    out_pc,
  output logic [FETCH_WIDTH-1:0]             out_pred_taken,
  output logic [CNT_W-1:0]                   q_count,
  output logic                               halted
);

  // state | meaning
  // RUN   | fetching whenever the queue has room for another bundle
  // HALT  | fetch stopped, queue keeps draining until a redirect
  typedef enum logic {ST_RUN, ST_HALT} state_e;

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
  logic                    inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]     resp_addr_q, resp_addr_d;
  logic [FETCH_WIDTH-1:0]  resp_mask_q, resp_mask_d;
  logic [FETCH_WIDTH-1:0]  resp_pt_q, resp_pt_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [INSTR_WIDTH-1:0]  q_instr_q [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0]  q_instr_d [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0]     q_pc_q [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0]     q_pc_d [QUEUE_DEPTH];
  logic                    q_pt_q [QUEUE_DEPTH];
  logic                    q_pt_d [QUEUE_DEPTH];

  logic                    space_ok;
  logic                    pred_taken;
  logic [FETCH_WIDTH-1:0]  lane_mask;
  logic [FETCH_WIDTH-1:0]  lane_pt;
  logic [CNT_W-1:0]        enq_n;
  logic [CNT_W-1:0]        deq_n;
  logic [PTR_W-1:0]        widx;
  logic [PTR_W-1:0]        ridx;

  // Room must be reserved for a response that lands this cycle before asking for another.
  assign space_ok   = (QUEUE_DEPTH - int'(count_q) - (inflight_q ? FETCH_WIDTH : 0)) >= FETCH_WIDTH;
  assign imem_req   = !reset && (state_q == ST_RUN) && !redirect_valid && !hlt && space_ok;
  assign imem_addr  = fetch_pc_q;
  assign pred_taken = bp_hit && bp_taken;
  assign q_count    = count_q;
  assign halted     = (state_q == ST_HALT);

  always_comb begin
    lane_mask = '0;
    lane_pt   = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_mask[i] = !pred_taken || (SLOT_W'(i) <= bp_slot);
      lane_pt[i]   = pred_taken && (SLOT_W'(i) == bp_slot);
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    inflight_d  = 1'b0;
    resp_addr_d = resp_addr_q;
    resp_mask_d = resp_mask_q;
    resp_pt_d   = resp_pt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    q_instr_d   = q_instr_q;
    q_pc_d      = q_pc_q;
    q_pt_d      = q_pt_q;
    enq_n       = '0;
    deq_n       = '0;
    widx        = '0;

    if (redirect_valid) begin
      state_d    = ST_RUN;
      fetch_pc_d = redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      // Predicted-taken responses carry a prefix mask, so valid lanes pack contiguously.
      if (inflight_q) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (resp_mask_q[i]) begin
            widx            = tail_q + PTR_W'(i);
            q_instr_d[widx] = imem_rdata[i*INSTR_WIDTH +: INSTR_WIDTH];
            q_pc_d[widx]    = resp_addr_q + PC_WIDTH'(i);
            q_pt_d[widx]    = resp_pt_q[i];
            enq_n           = enq_n + CNT_W'(1);
          end
        end
      end
      deq_n   = (CNT_W'(deq_count) < count_q) ? CNT_W'(deq_count) : count_q;
      tail_d  = tail_q + PTR_W'(enq_n);
      head_d  = head_q + PTR_W'(deq_n);
      count_d = count_q + enq_n - deq_n;

      if (imem_req) begin
        inflight_d  = 1'b1;
        resp_addr_d = fetch_pc_q;
        resp_mask_d = lane_mask;
        resp_pt_d   = lane_pt;
        fetch_pc_d  = pred_taken ? bp_target : fetch_pc_q + PC_WIDTH'(FETCH_WIDTH);
      end

      if ((state_q == ST_RUN) && hlt) begin
        state_d = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      fetch_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      resp_addr_q <= '0;
      resp_mask_q <= '0;
      resp_pt_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      resp_addr_q <= resp_addr_d;
      resp_mask_q <= resp_mask_d;
      resp_pt_q   <= resp_pt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    q_instr_q <= q_instr_d;
    q_pc_q    <= q_pc_d;
    q_pt_q    <= q_pt_d;
  end

  always_comb begin
    out_valid      = '0;
    out_instr      = '0;
    out_pc         = '0;
    out_pred_taken = '0;
    ridx           = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      ridx                                   = head_q + PTR_W'(i);
      out_valid[i]                           = count_q > CNT_W'(i);
      out_instr[i*INSTR_WIDTH +: INSTR_WIDTH] = q_instr_q[ridx];
      out_pc[i*PC_WIDTH +: PC_WIDTH]          = q_pc_q[ridx];
      out_pred_taken[i]                      = out_valid[i] && q_pt_q[ridx];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based reference model checked every cycle plus directed literal checks.
module tb_fetch_buffer;
  localparam int FW = 2;
  localparam int QD = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        bp_hit, bp_taken;
  logic [0:0]  bp_slot;
  logic [15:0] bp_target;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic [1:0]  deq_count;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  out_pred_taken;
  logic [3:0]  q_count;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  fetch_buffer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .bp_hit(bp_hit), .bp_taken(bp_taken), .bp_slot(bp_slot),
    .bp_target(bp_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .hlt(hlt), .deq_count(deq_count), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_pred_taken(out_pred_taken), .q_count(q_count), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Instruction memory: answers the request seen in the previous cycle.
  logic        mem_pend = 1'b0;
  logic [15:0] mem_addr = '0;
  initial begin
    imem_rdata = {2{32'hDEAD_BEEF}};
    forever begin
      @(posedge clk);
      #1;
      if (mem_pend) imem_rdata = {mem_word(mem_addr + 16'd1), mem_word(mem_addr)};
      else          imem_rdata = {2{32'hDEAD_BEEF}};
    end
  end

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
    logic        pt;
  } ent_t;

  ent_t        mq[$];
  ent_t        mpend[$];
  logic        m_inf  = 1'b0;
  logic [15:0] m_pc   = '0;
  logic        m_halt = 1'b0;

  always @(negedge clk) begin
    logic        exp_req;
    logic        tk;
    logic [15:0] a;
    int          n;
    int          nd;
    ent_t        e;
    if (reset) begin
      chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
      chk("rst_q_count", {60'd0, q_count}, 64'd0);
      chk("rst_out_valid", {62'd0, out_valid}, 64'd0);
      chk("rst_out_pred_taken", {62'd0, out_pred_taken}, 64'd0);
      chk("rst_halted", {63'd0, halted}, 64'd0);
      mq.delete();
      mpend.delete();
      m_inf    = 1'b0;
      m_pc     = 16'h0000;
      m_halt   = 1'b0;
      mem_pend = 1'b0;
    end else begin
      exp_req = !m_halt && !redirect_valid && !hlt &&
                ((QD - mq.size() - (m_inf ? FW : 0)) >= FW);
      chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
      if (exp_req) chk("imem_addr", {48'd0, imem_addr}, {48'd0, m_pc});
      chk("q_count", {60'd0, q_count}, 64'(mq.size()));
      chk("halted", {63'd0, halted}, {63'd0, m_halt});
      for (int i = 0; i < FW; i++) begin
        chk($sformatf("out_valid[%0d]", i), {63'd0, out_valid[i]}, {63'd0, (i < mq.size())});
        if (i < mq.size()) begin
          chk($sformatf("out_pc[%0d]", i), {48'd0, out_pc[i*16 +: 16]}, {48'd0, mq[i].pc});
          chk($sformatf("out_instr[%0d]", i), {32'd0, out_instr[i*32 +: 32]}, {32'd0, mq[i].instr});
          chk($sformatf("out_pred_taken[%0d]", i), {63'd0, out_pred_taken[i]}, {63'd0, mq[i].pt});
        end else begin
          chk($sformatf("out_pred_taken_idle[%0d]", i), {63'd0, out_pred_taken[i]}, 64'd0);
        end
      end
      mem_pend = imem_req;
      mem_addr = imem_addr;
      if (redirect_valid) begin
        mq.delete();
        mpend.delete();
        m_inf  = 1'b0;
        m_pc   = redirect_pc;
        m_halt = 1'b0;
      end else begin
        nd = (int'(deq_count) < mq.size()) ? int'(deq_count) : mq.size();
        for (int i = 0; i < nd; i++) void'(mq.pop_front());
        if (m_inf) foreach (mpend[j]) mq.push_back(mpend[j]);
        mpend.delete();
        m_inf = 1'b0;
        if (exp_req) begin
          tk = bp_hit && bp_taken;
          n  = tk ? int'(bp_slot) + 1 : FW;
          for (int i = 0; i < n; i++) begin
            a       = m_pc + 16'(i);
            e.pc    = a;
            e.instr = mem_word(a);
            e.pt    = tk && (i == int'(bp_slot));
            mpend.push_back(e);
          end
          m_inf = 1'b1;
          m_pc  = tk ? bp_target : m_pc + 16'(FW);
        end
        if (hlt) m_halt = 1'b1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bp_hit = 1'b0; bp_taken = 1'b0; bp_slot = '0; bp_target = '0;
    redirect_valid = 1'b0; redirect_pc = '0; hlt = 1'b0; deq_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("lit_rst_q_count", {60'd0, q_count}, 64'd0);
    chk("lit_rst_req", {63'd0, imem_req}, 64'd0);
    // C0: first request at reset pc
    reset = 1'b0; deq_count = 2'd2; #1;
    chk("lit_c0_req", {63'd0, imem_req}, 64'd1);
    chk("lit_c0_addr", {48'd0, imem_addr}, 64'h0);
    nxt(); #1;
    chk("lit_c1_addr", {48'd0, imem_addr}, 64'h2);
    for (int k = 2; k <= 5; k++) begin
      nxt(); #1;
      chk("lit_stream_addr", {48'd0, imem_addr}, 64'(2*k));
      chk("lit_stream_count", {60'd0, q_count}, 64'd2);
      chk("lit_stream_pc0", {48'd0, out_pc[15:0]}, 64'(2*(k-2)));
      chk("lit_stream_pc1", {48'd0, out_pc[31:16]}, 64'(2*(k-2)+1));
    end
    nxt(); deq_count = 2'd0;                 // C6
    nxt(); nxt(); #1;                        // C8
    chk("lit_c8_req", {63'd0, imem_req}, 64'd0);
    nxt(); #1;
    chk("lit_full_count", {60'd0, q_count}, 64'd8);
    nxt(); #1;                               // C10
    chk("lit_full_req", {63'd0, imem_req}, 64'd0);
    nxt(); deq_count = 2'd2; #1;             // C11
    chk("lit_c11_req", {63'd0, imem_req}, 64'd0);
    nxt(); deq_count = 2'd0; #1;             // C12
    chk("lit_c12_count", {60'd0, q_count}, 64'd6);
    chk("lit_c12_req", {63'd0, imem_req}, 64'd1);
    chk("lit_c12_addr", {48'd0, imem_addr}, 64'h10);
    chk("lit_c12_pc0", {48'd0, out_pc[15:0]}, 64'ha);
    nxt(); redirect_valid = 1'b1; redirect_pc = 16'h0040; deq_count = 2'd2; #1;  // C13
    chk("lit_c13_req", {63'd0, imem_req}, 64'd0);
    chk("lit_c13_count", {60'd0, q_count}, 64'd6);
    nxt(); redirect_valid = 1'b0; deq_count = 2'd0; #1;  // C14
    chk("lit_redir_count", {60'd0, q_count}, 64'd0);
    chk("lit_redir_addr", {48'd0, imem_addr}, 64'h40);
    nxt(); #1;                               // C15
    chk("lit_c15_addr", {48'd0, imem_addr}, 64'h42);
    chk("lit_c15_count", {60'd0, q_count}, 64'd0);
    nxt(); redirect_valid = 1'b1; redirect_pc = 16'h0004; #1;  // C16
    chk("lit_c16_count", {60'd0, q_count}, 64'd2);
    chk("lit_c16_pc0", {48'd0, out_pc[15:0]}, 64'h40);
    chk("lit_c16_instr0", {32'd0, out_instr[31:0]}, 64'hC0DE0040);
    nxt(); redirect_valid = 1'b0; deq_count = 2'd2;         // C17
    bp_hit = 1'b1; bp_taken = 1'b1; bp_slot = 1'b0; bp_target = 16'h0020; #1;
    chk("lit_bp_addr", {48'd0, imem_addr}, 64'h4);
    chk("lit_bp_req", {63'd0, imem_req}, 64'd1);
    nxt(); bp_hit = 1'b0; bp_taken = 1'b0; #1;              // C18
    chk("lit_bp_target", {48'd0, imem_addr}, 64'h20);
    nxt(); #1;                               // C19
    chk("lit_bp_count", {60'd0, q_count}, 64'd1);
    chk("lit_bp_valid", {62'd0, out_valid}, 64'b01);
    chk("lit_bp_pc0", {48'd0, out_pc[15:0]}, 64'h4);
    chk("lit_bp_pt", {62'd0, out_pred_taken}, 64'b01);
    nxt(); redirect_valid = 1'b1; redirect_pc = 16'h0006; deq_count = 2'd0; #1;  // C20
    chk("lit_c20_count", {60'd0, q_count}, 64'd2);
    chk("lit_c20_pc0", {48'd0, out_pc[15:0]}, 64'h20);
    chk("lit_c20_pt", {62'd0, out_pred_taken}, 64'b00);
    nxt(); redirect_valid = 1'b0; #1;        // C21
    chk("lit_c21_addr", {48'd0, imem_addr}, 64'h6);
    nxt(); hlt = 1'b1; #1;                   // C22
    chk("lit_hlt_req", {63'd0, imem_req}, 64'd0);
    chk("lit_hlt_pc", {48'd0, imem_addr}, 64'h8);
    nxt(); hlt = 1'b0; deq_count = 2'd1; #1; // C23
    chk("lit_halted", {63'd0, halted}, 64'd1);
    chk("lit_halt_count", {60'd0, q_count}, 64'd2);
    chk("lit_halt_req", {63'd0, imem_req}, 64'd0);
    nxt(); #1;                               // C24
    chk("lit_drain_count", {60'd0, q_count}, 64'd1);
    chk("lit_drain_pc0", {48'd0, out_pc[15:0]}, 64'h7);
    nxt(); #1;                               // C25
    chk("lit_drained", {60'd0, q_count}, 64'd0);
    chk("lit_still_halted", {63'd0, halted}, 64'd1);
    nxt(); redirect_valid = 1'b1; redirect_pc = 16'h0010; deq_count = 2'd0; #1;  // C26
    chk("lit_c26_req", {63'd0, imem_req}, 64'd0);
    nxt(); redirect_valid = 1'b0; #1;        // C27
    chk("lit_unhalt", {63'd0, halted}, 64'd0);
    chk("lit_unhalt_addr", {48'd0, imem_addr}, 64'h10);
    chk("lit_unhalt_req", {63'd0, imem_req}, 64'd1);
    nxt(); redirect_valid = 1'b1; redirect_pc = 16'hFFFE; deq_count = 2'd2;      // C28
    nxt(); redirect_valid = 1'b0; #1;        // C29
    chk("lit_wrap_addr0", {48'd0, imem_addr}, 64'hFFFE);
    nxt(); #1;                               // C30
    chk("lit_wrap_addr1", {48'd0, imem_addr}, 64'h0000);
    nxt(); bp_hit = 1'b1; bp_taken = 1'b1; bp_slot = 1'b1; bp_target = 16'h0100; #1;  // C31
    chk("lit_wrap_pc0", {48'd0, out_pc[15:0]}, 64'hFFFE);
    chk("lit_wrap_pc1", {48'd0, out_pc[31:16]}, 64'hFFFF);
    chk("lit_c31_addr", {48'd0, imem_addr}, 64'h2);
    nxt(); bp_hit = 1'b0; bp_taken = 1'b0; #1;              // C32
    chk("lit_slot1_target", {48'd0, imem_addr}, 64'h100);
    nxt(); #1;                               // C33
    chk("lit_slot1_count", {60'd0, q_count}, 64'd2);
    chk("lit_slot1_pc1", {48'd0, out_pc[31:16]}, 64'h3);
    chk("lit_slot1_pt", {62'd0, out_pred_taken}, 64'b10);
    nxt(); reset = 1'b1; deq_count = 2'd0; #1;              // C34
    chk("lit_midrst_count", {60'd0, q_count}, 64'd0);
    chk("lit_midrst_req", {63'd0, imem_req}, 64'd0);
    nxt(); reset = 1'b0; #1;                 // C35
    chk("lit_post_rst_req", {63'd0, imem_req}, 64'd1);
    chk("lit_post_rst_addr", {48'd0, imem_addr}, 64'h0);
    nxt(); nxt(); #1;                        // C37
    chk("lit_post_rst_count", {60'd0, q_count}, 64'd2);
    chk("lit_post_rst_pc0", {48'd0, out_pc[15:0]}, 64'h0);
    repeat (4) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
